// File: rtl/updown_counter_p.sv
// Up/down counter over the range 0..MAX_COUNT with synchronous load and a wrap pulse.
// Latency: Count and Wrap update one Clk edge after the inputs are sampled; Zero and AtMax are combinational.
// Backpressure: none; the counter steps on every edge that has En high and Load low.
//
// Ports:
//   Clk      - single clock; all state changes happen on its rising edge
//   reset    - asynchronous, active-low reset (Count = 0, Wrap = 0)
//   En       - count enable, one step per edge while high
//   UpOrDown - direction: 1 counts up, 0 counts down
//   Load     - synchronous load strobe, takes priority over En
//   LoadVal  - load value, clamped to MAX_COUNT
//   Count    - registered count value
//   Wrap     - registered one-cycle pulse, high while the wrapped value is on Count
//   Zero     - high when Count == 0
//   AtMax    - high when Count == MAX_COUNT
//
// Build option: define UPDOWN_SATURATE_EN to make the counter hold at the
// range ends instead of wrapping; Wrap is then tied low.
module updown_counter_p #(
    parameter int          WIDTH     = 8,
    parameter int unsigned MAX_COUNT = (2 ** WIDTH) - 1
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             En,
    input  logic             UpOrDown,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    output logic [WIDTH-1:0] Count,
    output logic             Wrap,
    output logic             Zero,
    output logic             AtMax
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] load_clamped;
    logic             at_zero;
    logic             at_max;
    logic             step_up;
    logic             step_dn;
    logic             wrap_d;

    assign at_zero = (count_q == '0);
    assign at_max  = (count_q == MAX_VAL);

    // Clamping the load keeps Count within 0..MAX_COUNT in every state.
    assign load_clamped = (LoadVal > MAX_VAL) ? MAX_VAL : LoadVal;

    // UpOrDown only matters on a real count step (Load low, En high).
    assign step_up = !Load && En &&  UpOrDown;
    assign step_dn = !Load && En && !UpOrDown;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (Load) begin
            count_d = load_clamped;
        end else if (step_up) begin
            if (at_max) begin
`ifdef UPDOWN_SATURATE_EN
                count_d = count_q;
`else
                count_d = '0;
                wrap_d  = 1'b1;
`endif
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (step_dn) begin
            if (at_zero) begin
`ifdef UPDOWN_SATURATE_EN
                count_d = count_q;
`else
                count_d = MAX_VAL;
                wrap_d  = 1'b1;
`endif
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

`ifdef UPDOWN_SATURATE_EN
    assign Wrap = 1'b0;
`else
    logic wrap_q;

    // Wrap is a single-cycle pulse: it is rewritten every edge, so load and
    // hold cycles clear it.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign Wrap = wrap_q;
`endif

    assign Count = count_q;
    assign Zero  = at_zero;
    assign AtMax = at_max;

endmodule

// File: tb/tb_updown_counter_p.sv
module tb_updown_counter_p;

    localparam int WIDTH     = 4;
    localparam int MAX_COUNT = 9;

    logic             Clk;
    logic             reset;
    logic             En;
    logic             UpOrDown;
    logic             Load;
    logic [WIDTH-1:0] LoadVal;
    logic [WIDTH-1:0] Count;
    logic             Wrap;
    logic             Zero;
    logic             AtMax;

    int checks;
    int errors;

    updown_counter_p #(
        .WIDTH    (WIDTH),
        .MAX_COUNT(MAX_COUNT)
    ) dut (
        .Clk     (Clk),
        .reset   (reset),
        .En      (En),
        .UpOrDown(UpOrDown),
        .Load    (Load),
        .LoadVal (LoadVal),
        .Count   (Count),
        .Wrap    (Wrap),
        .Zero    (Zero),
        .AtMax   (AtMax)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string      name;
        logic       ld;
        logic [3:0] lv;
        logic       en;
        logic       up;
        logic [3:0] exp_count;
        logic       exp_wrap;
        logic       exp_zero;
        logic       exp_max;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic [3:0] c, input logic w,
                           input logic z, input logic m);
        chk({name, ".count"}, 32'(Count), 32'(c));
        chk({name, ".wrap"},  32'(Wrap),  32'(w));
        chk({name, ".zero"},  32'(Zero),  32'(z));
        chk({name, ".atmax"}, 32'(AtMax), 32'(m));
    endtask

    // Drive inputs, take one rising edge, sample 1 time unit later.
    task automatic step(input logic ld, input logic [3:0] lv, input logic en, input logic up);
        Load     = ld;
        LoadVal  = lv;
        En       = en;
        UpOrDown = up;
        @(posedge Clk);
        #1;
    endtask

    task automatic add(input string n, input logic ld, input logic [3:0] lv, input logic en,
                       input logic up, input logic [3:0] c, input logic w);
        vec_t v;
        v.name = n; v.ld = ld; v.lv = lv; v.en = en; v.up = up;
        v.exp_count = c; v.exp_wrap = w;
        v.exp_zero  = (c == 4'd0);
        v.exp_max   = (c == 4'd9);
        vecs.push_back(v);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        En       = 1'b0;
        UpOrDown = 1'b0;
        Load     = 1'b0;
        LoadVal  = '0;

        // Count up 12 edges from reset: 1..9, 0 (wrap), 1, 2.
        add("up1", 0, 0, 1, 1, 4'd1, 0);
        add("up2", 0, 0, 1, 1, 4'd2, 0);
        add("up3", 0, 0, 1, 1, 4'd3, 0);
        add("up4", 0, 0, 1, 1, 4'd4, 0);
        add("up5", 0, 0, 1, 1, 4'd5, 0);
        add("up6", 0, 0, 1, 1, 4'd6, 0);
        add("up7", 0, 0, 1, 1, 4'd7, 0);
        add("up8", 0, 0, 1, 1, 4'd8, 0);
        add("up9", 0, 0, 1, 1, 4'd9, 0);
        add("upwrap", 0, 0, 1, 1, 4'd0, 1);
        add("up11", 0, 0, 1, 1, 4'd1, 0);
        add("up12", 0, 0, 1, 1, 4'd2, 0);
        // Load above range clamps to 9, then count down.
        add("ld15", 1, 4'd15, 0, 0, 4'd9, 0);
        add("dn1", 0, 0, 1, 0, 4'd8, 0);
        add("dn2", 0, 0, 1, 0, 4'd7, 0);
        add("dn3", 0, 0, 1, 0, 4'd6, 0);
        add("hold", 0, 0, 0, 1, 4'd6, 0);
        // Down wrap from 0 to 9.
        add("ld0", 1, 4'd0, 0, 1, 4'd0, 0);
        add("dnwrap", 0, 0, 1, 0, 4'd9, 1);
        add("holdmax", 0, 0, 0, 0, 4'd9, 0);
        // Load wins over a would-be up wrap; no Wrap.
        add("ldsupup", 1, 4'd3, 1, 1, 4'd3, 0);
        add("ld0b", 1, 4'd0, 0, 0, 4'd0, 0);
        // Load wins over a would-be down wrap; no Wrap.
        add("ldsupdn", 1, 4'd10, 1, 0, 4'd9, 0);
        add("ld4", 1, 4'd4, 0, 0, 4'd4, 0);
        add("holddir", 0, 0, 0, 0, 4'd4, 0);

        // Asynchronous reset between edges.
        @(negedge Clk);
        reset = 1'b0;
        #1;
        chk_all("rst", 4'd0, 1'b0, 1'b1, 1'b0);
        #2;
        reset = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].up);
            chk_all(vecs[i].name, vecs[i].exp_count, vecs[i].exp_wrap,
                    vecs[i].exp_zero, vecs[i].exp_max);
        end

        // Reset pulse between edges while Count=5: immediate clear.
        step(1, 4'd5, 0, 0);
        chk("pre_rst.count", 32'(Count), 32'd5);
        #2;
        reset = 1'b0;
        #1;
        chk_all("midrst", 4'd0, 1'b0, 1'b1, 1'b0);
        #1;
        reset = 1'b1;
        // First edge after release evaluates Load normally.
        step(1, 4'd7, 1, 1);
        chk_all("post_rst_ld", 4'd7, 1'b0, 1'b0, 1'b0);

        // Reset during a Wrap pulse leaves no residual pulse.
        step(1, 4'd9, 0, 0);
        step(0, 4'd0, 1, 1);
        chk_all("wrap_pre", 4'd0, 1'b1, 1'b1, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        chk("wrap_rst.wrap", 32'(Wrap), 32'd0);
        reset = 1'b1;
        step(0, 4'd0, 0, 1);
        chk_all("wrap_after", 4'd0, 1'b0, 1'b1, 1'b0);

        // Enabled up step right after a wrap continues counting.
        step(0, 4'd0, 1, 1);
        chk_all("resume", 4'd1, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
